// File: rtl/scmi_doorbell_ctrl_if.sv
// Register port of the SCMI doorbell controller: single-cycle grant and
// a registered response one cycle after every granted request.
interface scmi_doorbell_ctrl_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [31:0]           wdata_i;
  logic                  gnt_o;
  logic                  rvalid_o;
  logic [31:0]           rdata_o;
  logic                  err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/scmi_doorbell_ctrl.sv
// Multi-channel SCMI doorbell controller.
// Each channel runs a channel-status FSM rung by register writes or by
// rising edges on db_i, and raises a callee interrupt and a caller
// completion pulse.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | channel free, caller may ring
// PENDING | doorbell rung, waiting for the callee to acknowledge
// SERVICE | callee acknowledged, message being processed
//
// Channel c lives at byte offset c*16: +0 STATUS, +4 FLAGS, +8 RING, +C CTRL.
module scmi_doorbell_ctrl #(
  parameter int NUM_CHANNELS = 8,
  parameter int ADDR_WIDTH   = 12,
  parameter bit IRQ_PULSE    = 1'b0,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  scmi_doorbell_ctrl_if.slave     bus,
  input  logic [NUM_CHANNELS-1:0] db_i,
  output logic [NUM_CHANNELS-1:0] irq_o,
  output logic [NUM_CHANNELS-1:0] done_o
);

  localparam int CH_W = ADDR_WIDTH - 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e                 state_q [NUM_CHANNELS];
  state_e                 state_d [NUM_CHANNELS];
  state_e                 base_st [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]   cnt_q   [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]   cnt_d   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] irq_en_q, irq_en_d;
  logic [NUM_CHANNELS-1:0] ovf_q, ovf_d;
  logic [NUM_CHANNELS-1:0] irq_q, irq_d;
  logic [NUM_CHANNELS-1:0] done_q, done_d;
  logic [NUM_CHANNELS-1:0] db_q, db_d;
  logic                    db_arm_q, db_arm_d;
  logic                    rvalid_q, rvalid_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [CH_W-1:0]         ch_idx;
  logic [1:0]              reg_off;
  logic                    addr_hit;
  logic                    wr_en;
  logic [NUM_CHANNELS-1:0] sel_ch;
  logic [NUM_CHANNELS-1:0] wr_flags, ring_reg, ack_req, done_req, clr_req;
  logic [NUM_CHANNELS-1:0] db_rise, ring_evt, ring_ok, done_acc;
  logic                    unused_wdata;

  assign ch_idx   = bus.addr_i[ADDR_WIDTH-1:4];
  assign reg_off  = bus.addr_i[3:2];
  assign addr_hit = (bus.addr_i[1:0] == 2'b00) && (32'(ch_idx) < NUM_CHANNELS);
  assign wr_en    = bus.req_i & bus.we_i & addr_hit;
  assign unused_wdata = ^bus.wdata_i[31:3];

  // db_arm_q keeps a line held high across reset release from looking like an edge.
  assign db_rise  = db_i & ~db_q & {NUM_CHANNELS{db_arm_q}};
  assign db_d     = db_i;
  assign db_arm_d = 1'b1;

  assign bus.gnt_o    = bus.req_i;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.err_o    = err_q;
  assign irq_o        = irq_q;
  assign done_o       = done_q;

  // Per-channel write strobes decoded from the register port.
  always_comb begin
    sel_ch   = '0;
    wr_flags = '0;
    ring_reg = '0;
    ack_req  = '0;
    done_req = '0;
    clr_req  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      sel_ch[c]   = (ch_idx == CH_W'(c));
      wr_flags[c] = wr_en & sel_ch[c] & (reg_off == 2'd1);
      ring_reg[c] = wr_en & sel_ch[c] & (reg_off == 2'd2) & bus.wdata_i[0];
      ack_req[c]  = wr_en & sel_ch[c] & (reg_off == 2'd3) & bus.wdata_i[0];
      done_req[c] = wr_en & sel_ch[c] & (reg_off == 2'd3) & bus.wdata_i[1];
      clr_req[c]  = wr_en & sel_ch[c] & (reg_off == 2'd3) & bus.wdata_i[2];
    end
  end

  // Channel FSM next state, ring accounting and interrupt/completion outputs.
  // DONE is resolved first so a ring landing in the same cycle sees IDLE and
  // is accepted; a clear resets the counter before the same-cycle ring counts.
  always_comb begin
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    irq_d    = '0;
    done_d   = '0;
    ring_evt = '0;
    ring_ok  = '0;
    done_acc = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      state_d[c] = state_q[c];
      base_st[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];

      if (wr_flags[c]) irq_en_d[c] = bus.wdata_i[0];

      ring_evt[c] = ring_reg[c] | db_rise[c];
      done_acc[c] = done_req[c] && (state_q[c] != ST_IDLE);

      if (done_acc[c]) base_st[c] = ST_IDLE;
      else if (ack_req[c] && (state_q[c] == ST_PENDING)) base_st[c] = ST_SERVICE;

      ring_ok[c] = ring_evt[c] && (base_st[c] == ST_IDLE);
      state_d[c] = ring_ok[c] ? ST_PENDING : base_st[c];

      ovf_d[c] = (ovf_q[c] & ~clr_req[c]) | (ring_evt[c] & ~ring_ok[c]);

      cnt_d[c] = clr_req[c] ? '0 : cnt_q[c];
      if (ring_evt[c] && (cnt_d[c] != '1)) cnt_d[c] = cnt_d[c] + CNT_WIDTH'(1);

      done_d[c] = done_acc[c];
      if (IRQ_PULSE) irq_d[c] = ring_ok[c] & irq_en_d[c];
      else           irq_d[c] = (state_d[c] == ST_PENDING) & irq_en_d[c];
    end
  end

  // Read data and error response; reads see the state before any same-cycle write.
  always_comb begin
    rvalid_d = bus.req_i;
    rdata_d  = '0;
    err_d    = 1'b0;
    if (bus.req_i) begin
      if (!addr_hit) begin
        err_d = 1'b1;
      end else if (!bus.we_i) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
          if (sel_ch[c]) begin
            case (reg_off)
              2'd0: begin
                rdata_d[0]               = (state_q[c] == ST_IDLE);
                rdata_d[1]               = ovf_q[c];
                rdata_d[3:2]             = state_q[c];
                rdata_d[8 +: CNT_WIDTH]  = cnt_q[c];
              end
              2'd1:    rdata_d[0] = irq_en_q[c];
              default: rdata_d    = '0;
            endcase
          end
        end
      end
    end
  end

  // All state registers, reset asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= ST_IDLE;
        cnt_q[c]   <= '0;
      end
      irq_en_q <= '0;
      ovf_q    <= '0;
      irq_q    <= '0;
      done_q   <= '0;
      db_q     <= '0;
      db_arm_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      done_q   <= done_d;
      db_q     <= db_d;
      db_arm_q <= db_arm_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/scmi_doorbell_ctrl.md
Name: scmi_doorbell_ctrl

Overview:
- Multi-channel SCMI doorbell controller between agents (AP cores, external masters) and the PMS cores.
- Each channel holds an SCMI channel-status state machine. Doorbells ring from register writes or from hardware lines.
- Raises per-channel callee interrupts, gated by the channel flag (polling vs interrupt), and per-channel completion pulses back to the caller.
- Sits on a peripheral register port; its irq_o lines feed the PMS external interrupt inputs.

Parameters:
- NUM_CHANNELS, 8, number of independent SCMI channels (1..32).
- ADDR_WIDTH, 12, byte address width of the register port; must satisfy ADDR_WIDTH >= log2(NUM_CHANNELS)+4.
- IRQ_PULSE, 0, 0 = irq_o is a level held until ACK; 1 = irq_o is a single-cycle pulse on entry to PENDING.
- CNT_WIDTH, 8, width of the per-channel saturating ring counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  register request
- we_i  in  1  1 = write
- addr_i  in  ADDR_WIDTH  byte address
- wdata_i  in  32  write data
- gnt_o  out  1  grant; equals req_i (combinational)
- rvalid_o  out  1  response valid, one cycle after granted request (reads and writes)
- rdata_o  out  32  read data, valid with rvalid_o
- err_o  out  1  with rvalid_o: address unmapped or channel >= NUM_CHANNELS
- db_i  in  NUM_CHANNELS  hardware doorbell lines, rising-edge sensitive
- irq_o  out  NUM_CHANNELS  callee interrupt per channel
- done_o  out  NUM_CHANNELS  one-cycle completion pulse to caller per channel

Behaviour:
- Register map: channel c at base c*16.
  - +0x0 STATUS (RO): bit0 free, bit1 overflow (sticky), bits[3:2] state, bits[15:8] ring count.
  - +0x4 FLAGS (RW): bit0 irq_en.
  - +0x8 RING (W1): bit0 rings the doorbell.
  - +0xC CTRL (W1): bit0 ACK, bit1 DONE, bit2 clear overflow and ring count.
  - Writes to RO fields are ignored. Reads of write-only registers return 0.
- Per-channel FSM, encoding IDLE=0, PENDING=1, SERVICE=2:
  - IDLE --ring--> PENDING
  - PENDING --ACK--> SERVICE
  - PENDING or SERVICE --DONE--> IDLE
  - ACK in IDLE or SERVICE: ignored. DONE in IDLE: ignored.
- free = (state == IDLE).
- ring event = RING write with bit0 = 1, OR a db_i rising edge. db_i is registered once for edge detection, so the event is seen one cycle after the edge.
- Ring in PENDING or SERVICE: ring dropped, overflow set to 1.
- Ring counter: increments on every ring event, accepted or dropped; saturates at all-ones.
- Register ring and db_i edge on the same channel in the same cycle count as one ring event.
- DONE and ring on the same channel in the same cycle:
  - Next state is PENDING; the ring is accepted, no overflow.
  - done_o pulses.
  - In the SERVICE case with irq_en=1, irq_o re-asserts the next cycle.
- irq_o[c]:
  - Level mode: registered (PENDING && irq_en); deasserts the cycle after ACK or DONE, or after irq_en is cleared.
  - Pulse mode: one cycle, registered, on entry to PENDING if irq_en.
  - Setting irq_en while already PENDING: level mode asserts; pulse mode does not pulse.
- done_o[c]: one-cycle registered pulse on every accepted DONE.
- Overflow clear (CTRL bit2) and a dropped ring in the same cycle: overflow stays set, count reflects the new ring.
- Register timing:
  - Write side effects take effect on the clock edge of the granted request.
  - Reads return the pre-write state.
  - rvalid_o is a registered req_i; back-to-back requests every cycle are supported.
- Reset, async at any time:
  - All FSMs IDLE, FLAGS=0, overflow=0, counters=0, db_i edge register=0.
  - irq_o=0, done_o=0, rvalid_o=0, rdata_o=0, err_o=0.
  - A db_i held high across reset release does not ring.

Test Plan:
- Write FLAGS0=1, RING0=1 → next cycle STATUS0 reads 0x0000_0104 (free=0, PENDING, count 1); irq_o[0]=1 (level); write CTRL0=1 → irq_o[0]=0, STATUS0=0x0000_0108; write CTRL0=2 → done_o[0] one-cycle pulse, STATUS0=0x0000_0101.
- db_i = all ones for 5 ns (one cycle), FLAGS all 1 → every irq_o set one cycle after the edge; holding db_i high causes no further rings; each channel count = 1.
- RING channel 3 twice with no ACK → second ring dropped, STATUS3 bit1=1, count=2; CTRL3=4 clears both; state still PENDING.
- Channel 2 in SERVICE, DONE via CTRL2 while db_i[2] edge lands the same cycle → done_o[2] pulses, state PENDING, overflow=0, irq_o[2] re-asserts.
- IRQ_PULSE=1, FLAGS=0, RING, then set FLAGS=1 → no pulse; DONE, RING again → exactly one-cycle irq_o pulse.
- Assert rst_ni low while channel 1 is PENDING with irq_o high → irq_o immediately 0, STATUS1 reads 0x0000_0001 after release; read of addr NUM_CHANNELS*16 → err_o=1, rdata_o=0.
